adc_sequencer: RTL
==================

ADC_SEQUENCER -- requirements
Module: adc_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- LOCK_STABLE_CYCLES, 1024, consecutive cycles pll_lock must stay high before arming.
- ARM_DELAY_CYCLES, 24000, cycles adc_en is held low before each ADC start (1 ms at 24 MHz).
- WDOG_CYCLES, 4096, maximum adc_done-to-adc_done gap tolerated in RUN.
- DISP_DECIM, 16, mag_rdy pulses per display update.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- sys_clk, in, 1, sole clock.
- rst_n, in, 1, reset; asynchronous, active-low.
- pll_lock, in, 1, PLL lock status; asynchronous to nothing, already in the sys_clk domain.
- adc_done, in, 1, one-cycle frame-complete pulse from the ADC interface.
- mag_rdy, in, 1, one-cycle pulse, mag_val valid.
- mag_val, in, 16, Goertzel magnitude.
- adc_en, out, 1, ADC interface enable.
- dsp_en, out, 1, Goertzel manager ready/enable.
- disp_data, out, 8, LED bar value.
- disp_strobe, out, 1, one-cycle pulse when disp_data updates.
- restart_cnt, out, 8, watchdog restart count.
- state_o, out, 3, current state encoding.

Function
REQ-003 The FSM SHALL have the states IDLE=0, LOCK=1, ARM=2, RUN=3 and FAULT=4; the encodings SHALL appear on state_o.
REQ-004 IDLE SHALL move to LOCK on the first edge that samples pll_lock=1.
REQ-005 LOCK SHALL move to ARM after exactly LOCK_STABLE_CYCLES edges in LOCK with pll_lock=1.
REQ-006 ARM SHALL move to RUN after exactly ARM_DELAY_CYCLES edges in ARM.
REQ-007 pll_lock=0 sampled in any non-IDLE state SHALL force IDLE on that edge; this takes priority over every other transition.
REQ-008 adc_en and dsp_en SHALL be registered and high exactly while state is RUN; both SHALL be low in every other state.
REQ-009 In RUN, a watchdog counter SHALL:
- clear to 0 on entry to RUN and on each adc_done;
- otherwise increment by 1 each cycle.
REQ-010 When the watchdog count equals WDOG_CYCLES-1 and adc_done=0, the FSM SHALL go to FAULT.
REQ-011 If adc_done coincides with expiry, adc_done SHALL win and the FSM SHALL stay in RUN.
REQ-012 FAULT SHALL last exactly one cycle, then go to ARM, so the ADC restart is delayed and realigned.
REQ-013 On entry to FAULT, restart_cnt SHALL increment, saturating at 255.
REQ-014 A decimation counter (width clog2(DISP_DECIM)) SHALL count mag_rdy pulses seen in RUN, modulo DISP_DECIM.
REQ-015 The decimation counter SHALL reset to 0 whenever the FSM is not in RUN.
REQ-016 mag_rdy outside RUN SHALL be ignored.
REQ-017 A mag_rdy sampled in RUN while the decimation count is 0 SHALL, on that same edge:
- load disp_data with the saturated value: 8'hFF if mag_val[15:8]!=0, else mag_val[7:0];
- pulse disp_strobe high for one cycle.
This gives 1-cycle latency, and the first mag_rdy after entering RUN always updates the display.
REQ-018 disp_data SHALL hold its value across state changes, including IDLE and FAULT.
REQ-019 All counters SHALL be wide enough for their parameter; parameters SHALL be at least 1.

Reset
REQ-020 rst_n=0 SHALL asynchronously force:
- state IDLE;
- adc_en=0, dsp_en=0, disp_strobe=0;
- disp_data=8'h00, restart_cnt=8'h00;
- all internal counters to 0.
REQ-021 Release of rst_n SHALL take effect on the next sys_clk edge; reset mid-RUN SHALL drop adc_en immediately, without waiting for a clock.

Verification
REQ-022 With LOCK=4, ARM=8, WDOG=16 and DECIM=4, a bench SHALL cover the following directed scenarios:
- Bring-up: pll_lock rises and adc_done pulses every 10 cycles -> state LOCK after edge 0, ARM after edge 4, RUN and adc_en=1 after edge 12; restart_cnt stays 0.
- Watchdog: RUN with adc_done stopped -> FAULT on the 16th cycle after the last adc_done, restart_cnt=1, adc_en=0; adc_en returns high 9 cycles later (1 FAULT + 8 ARM).
- Tie: adc_done arrives exactly on the expiry cycle -> no FAULT and the watchdog clears.
- Lock loss: pll_lock drops during ARM and later during RUN -> IDLE on that edge with adc_en=0; re-lock requires a full LOCK+ARM sequence.
- Decimation/saturation: 8 mag_rdy pulses in RUN with mag_val=0x0042,...,0x0123 -> exactly 2 disp_strobe pulses, on the 1st and 5th; disp_data=0x42 and 0xFF respectively.
- Async reset: rst_n asserted mid-RUN between clock edges -> adc_en low before the next edge; after release, state IDLE and all outputs 0.
- Saturation: 300 forced faults -> restart_cnt holds at 255.

Source files
------------

// File: rtl/adc_sequencer.sv
// adc_sequencer: power-up and run-time sequencer for the ADC / Goertzel chain.
//   Waits for a stable PLL lock, holds the ADC off for an arming delay, then
//   runs the ADC and DSP. A frame watchdog restarts the ADC via FAULT -> ARM,
//   and a decimated, saturated magnitude feeds an 8-bit LED bar.
// Ports:
//   sys_clk, rst_n           clock, async active-low reset
//   pll_lock                 PLL lock status (sys_clk domain)
//   adc_done                 one-cycle frame-complete pulse
//   mag_rdy, mag_val[15:0]   magnitude valid pulse and value
//   adc_en, dsp_en           registered enables, high only in RUN
//   disp_data[7:0]           LED bar value, disp_strobe pulses on update
//   restart_cnt[7:0]         saturating watchdog restart count
//   state_o[2:0]             current state encoding
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for pll_lock
// LOCK  | pll_lock must stay high LOCK_STABLE_CYCLES edges
// ARM   | ADC held off ARM_DELAY_CYCLES edges before (re)start
// RUN   | ADC and DSP enabled, watchdog and display decimation active
// FAULT | one-cycle watchdog restart, counts restart_cnt, goes to ARM
module adc_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int ARM_DELAY_CYCLES   = 24000,
  parameter int WDOG_CYCLES        = 4096,
  parameter int DISP_DECIM         = 16
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        pll_lock,
  input  logic        adc_done,
  input  logic        mag_rdy,
  input  logic [15:0] mag_val,
  output logic        adc_en,
  output logic        dsp_en,
  output logic [7:0]  disp_data,
  output logic        disp_strobe,
  output logic [7:0]  restart_cnt,
  output logic [2:0]  state_o
);

  localparam int LOCK_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int ARM_W  = (ARM_DELAY_CYCLES > 1) ? $clog2(ARM_DELAY_CYCLES) : 1;
  localparam int TMR_W  = (LOCK_W > ARM_W) ? LOCK_W : ARM_W;
  localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam int DEC_W  = (DISP_DECIM > 1) ? $clog2(DISP_DECIM) : 1;

  // The LOCK and ARM phases share one down-counter; each phase loads its
  // length minus one on entry and advances when the count reaches zero.
  localparam logic [TMR_W-1:0]  LOCK_LOAD = TMR_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  ARM_LOAD  = TMR_W'(ARM_DELAY_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DISP_DECIM - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOCK  = 3'd1,
    ST_ARM   = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [DEC_W-1:0]  decim_q, decim_d;
  logic [7:0]        disp_data_q, disp_data_d;
  logic              disp_strobe_q, disp_strobe_d;
  logic [7:0]        restart_cnt_q, restart_cnt_d;
  logic              run_en_q, run_en_d;

  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_q;
    wdog_d        = '0;
    decim_d       = decim_q;
    disp_data_d   = disp_data_q;
    disp_strobe_d = 1'b0;
    restart_cnt_d = restart_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (pll_lock) begin
          state_d = ST_LOCK;
          tmr_d   = LOCK_LOAD;
        end
      end
      ST_LOCK: begin
        if (tmr_q == '0) begin
          state_d = ST_ARM;
          tmr_d   = ARM_LOAD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_ARM: begin
        if (tmr_q == '0) begin
          state_d = ST_RUN;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_RUN: begin
        // adc_done beats a coincident expiry.
        if (adc_done) begin
          wdog_d = '0;
        end else if (wdog_q == WDOG_LAST) begin
          state_d = ST_FAULT;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
        if (mag_rdy) begin
          decim_d = (decim_q == DEC_LAST) ? '0 : decim_q + 1'b1;
          if (decim_q == '0) begin
            disp_data_d   = (|mag_val[15:8]) ? 8'hFF : mag_val[7:0];
            disp_strobe_d = 1'b1;
          end
        end
      end
      ST_FAULT: begin
        state_d = ST_ARM;
        tmr_d   = ARM_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase

    // Lock loss overrides every other transition.
    if (state_q != ST_IDLE && !pll_lock) begin
      state_d = ST_IDLE;
    end

    // Watchdog and decimation only live in RUN; clearing them whenever the
    // next state is not RUN also gives a clean count on every RUN entry.
    if (state_d != ST_RUN) begin
      wdog_d  = '0;
      decim_d = '0;
    end

    if (state_d == ST_FAULT && state_q != ST_FAULT && restart_cnt_q != 8'hFF) begin
      restart_cnt_d = restart_cnt_q + 1'b1;
    end
  end

  // Enables are decoded from the next state so they change on the same edge
  // as state_o.
  assign run_en_d = (state_d == ST_RUN);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      tmr_q         <= '0;
      wdog_q        <= '0;
      decim_q       <= '0;
      disp_data_q   <= 8'h00;
      disp_strobe_q <= 1'b0;
      restart_cnt_q <= 8'h00;
      run_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      wdog_q        <= wdog_d;
      decim_q       <= decim_d;
      disp_data_q   <= disp_data_d;
      disp_strobe_q <= disp_strobe_d;
      restart_cnt_q <= restart_cnt_d;
      run_en_q      <= run_en_d;
    end
  end

  assign adc_en      = run_en_q;
  assign dsp_en      = run_en_q;
  assign disp_data   = disp_data_q;
  assign disp_strobe = disp_strobe_q;
  assign restart_cnt = restart_cnt_q;
  assign state_o     = state_q;

endmodule
